// File: rtl/ram_partition_ctrl.sv
// ram_partition_ctrl: partition gating and RAM re-init sequencer; init writes exist only when RAM_PART_INIT_EN is defined
module ram_partition_ctrl #(
  parameter int DEPTH         = 64,
  parameter int INDEX         = 6,
  parameter int WIDTH         = 32,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2,
  parameter int RESET_SEQ     = 0,
  parameter int SEQ_START     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reconfig_i,
  input  logic [NUM_PARTS_LOG:0]   activeParts_i,
  input  logic                     busy_i,
  output logic [NUM_PARTS-1:0]     partitionGated_o,
  output logic                     initWrEn_o,
  output logic [INDEX-1:0]         initAddr_o,
  output logic [WIDTH-1:0]         initData_o,
  output logic                     ramReady_o,
  output logic                     reconfigAck_o
);
  localparam int cntW = NUM_PARTS_LOG + 1;
  localparam logic [WIDTH-1:0] seqBase = RESET_SEQ != 0 ? WIDTH'(SEQ_START) : '0;
  typedef enum logic [2:0] {INIT, IDLE, DRAIN, GATE, DONE} stateT;
  stateT state, stateNext;
  logic [cntW-1:0] activeCount, countNext, clampedReq;
  logic [NUM_PARTS-1:0] newMask, maskNext;
  logic postReset, postResetNext;
  assign clampedReq = activeParts_i == '0 ? cntW'(1) :
                      activeParts_i > cntW'(NUM_PARTS) ? cntW'(NUM_PARTS) : activeParts_i;
  // partitions at or above the latched active count are gated
  always_comb begin
    newMask = '0;
    for (int p = 0; p < NUM_PARTS; p++) newMask[p] = p >= int'(activeCount);
  end
`ifdef RAM_PART_INIT_EN
  localparam int partSize = DEPTH / NUM_PARTS;
  logic [NUM_PARTS-1:0] pending, pendingNext;
  logic [NUM_PARTS_LOG-1:0] curPart;
  logic [INDEX-1:0] offs, offsNext, curAddr, addrNext;
  logic wrEnNext;
  logic [WIDTH-1:0] dataNext;
  // the lowest pending partition is initialised first
  always_comb begin
    curPart = '0;
    for (int p = NUM_PARTS - 1; p >= 0; p--) if (pending[p]) curPart = NUM_PARTS_LOG'(p);
    curAddr = INDEX'(int'(curPart) * partSize) + offs;
  end
`else
  assign initWrEn_o = 1'b0;
  assign initAddr_o = INDEX'(DEPTH - 1) & {INDEX{initWrEn_o}};
  assign initData_o = seqBase & {WIDTH{initWrEn_o}};
`endif
  // next state and next registered outputs
  always_comb begin
    stateNext = state;
    countNext = activeCount;
    maskNext = partitionGated_o;
    postResetNext = postReset;
`ifdef RAM_PART_INIT_EN
    pendingNext = pending;
    offsNext = offs;
    wrEnNext = 1'b0;
    addrNext = '0;
    dataNext = '0;
`endif
    case (state)
      IDLE: if (reconfig_i) begin
        stateNext = DRAIN;
        countNext = clampedReq;
      end
      DRAIN: if (!busy_i) stateNext = GATE;
      GATE: begin
        maskNext = newMask;
`ifdef RAM_PART_INIT_EN
        pendingNext = partitionGated_o & ~newMask;
        stateNext = INIT;
`else
        stateNext = DONE;
`endif
      end
      DONE: begin
        stateNext = IDLE;
        postResetNext = 1'b0;
      end
      default: begin
`ifdef RAM_PART_INIT_EN
        if (pending == '0) stateNext = DONE;
        else begin
          wrEnNext = 1'b1;
          addrNext = curAddr;
          dataNext = RESET_SEQ != 0 ? seqBase + WIDTH'(curAddr) : '0;
          offsNext = offs == INDEX'(partSize - 1) ? '0 : offs + INDEX'(1);
          pendingNext = offs == INDEX'(partSize - 1) ? pending & ~(NUM_PARTS'(1) << curPart) : pending;
          stateNext = pendingNext == '0 ? DONE : INIT;
        end
`else
        stateNext = DONE;
`endif
      end
    endcase
  end
  // state and output registers; reset aborts and restarts a full init
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef RAM_PART_INIT_EN
      state <= INIT;
      pending <= '1;
      offs <= '0;
      initWrEn_o <= 1'b0;
      initAddr_o <= '0;
      initData_o <= '0;
`else
      state <= DONE;
`endif
      activeCount <= cntW'(NUM_PARTS);
      partitionGated_o <= '0;
      postReset <= 1'b1;
      ramReady_o <= 1'b0;
      reconfigAck_o <= 1'b0;
    end else begin
`ifdef RAM_PART_INIT_EN
      pending <= pendingNext;
      offs <= offsNext;
      initWrEn_o <= wrEnNext;
      initAddr_o <= addrNext;
      initData_o <= dataNext;
`endif
      state <= stateNext;
      activeCount <= countNext;
      partitionGated_o <= maskNext;
      postReset <= postResetNext;
      ramReady_o <= state == IDLE;
      reconfigAck_o <= state == DONE && !postReset;
    end
  end
endmodule

// File: tb/tb_ram_partition_ctrl.sv
// tb_ram_partition_ctrl: table, random and corner-case checks of ram_partition_ctrl
module tb_ram_partition_ctrl;
  localparam int seqStart = 100;
`ifdef RAM_PART_INIT_EN
  localparam bit initEn = 1'b1;
`else
  localparam bit initEn = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, reconfig_i = 1'b0, busy_i = 1'b0;
  logic [2:0] activeParts_i = '0;
  logic [3:0] partitionGated_o;
  logic initWrEn_o, ramReady_o, reconfigAck_o;
  logic [5:0] initAddr_o;
  logic [31:0] initData_o;

  ram_partition_ctrl #(.DEPTH(64), .INDEX(6), .WIDTH(32), .NUM_PARTS(4), .NUM_PARTS_LOG(2),
                       .RESET_SEQ(1), .SEQ_START(seqStart)) dut (
    .clk(clk), .reset(reset), .reconfig_i(reconfig_i), .activeParts_i(activeParts_i), .busy_i(busy_i),
    .partitionGated_o(partitionGated_o), .initWrEn_o(initWrEn_o), .initAddr_o(initAddr_o),
    .initData_o(initData_o), .ramReady_o(ramReady_o), .reconfigAck_o(reconfigAck_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int data; int c;} wrT;
  wrT wrQ[$];
  int ackQ[$];
  int expQ[$];
  int fallCyc = -1, riseCyc = -1, maskCyc = -1;
  logic prevReady = 1'b0;
  logic [3:0] prevMask = '0;
  logic [3:0] curMask = '0;
  int nCmp = 0, nBad = 0;

  // observe outputs half a cycle away from the active edge
  always @(negedge clk) begin
    if (initWrEn_o === 1'b1) wrQ.push_back('{int'(initAddr_o), int'(initData_o), cyc});
    if (reconfigAck_o === 1'b1) ackQ.push_back(cyc);
    if (prevReady === 1'b1 && ramReady_o === 1'b0) fallCyc = cyc;
    if (prevReady !== 1'b1 && ramReady_o === 1'b1) riseCyc = cyc;
    if (partitionGated_o !== prevMask) maskCyc = cyc;
    prevReady = ramReady_o;
    prevMask = partitionGated_o;
  end

  task automatic chk(input string name, input int got, input int exp);
    nCmp++;
    if (got != exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [3:0] modelMask(input int n);
    int c;
    c = n < 1 ? 1 : (n > 4 ? 4 : n);
    return 4'(16 - (1 << c));
  endfunction

  task automatic checkWrites(input int c0);
    int bad;
    bad = -1;
    chk("wrCount", wrQ.size(), expQ.size());
    if (expQ.size() > 0) begin
      for (int j = 0; j < expQ.size() && j < wrQ.size(); j++)
        if (bad < 0 && (wrQ[j].addr != expQ[j] || wrQ[j].data != seqStart + expQ[j] || wrQ[j].c != c0 + j)) bad = j;
      nCmp++;
      if (bad >= 0) begin
        nBad++;
        $display("FAIL writes[%0d]: got addr %0d data %0d cyc %0d, expected addr %0d data %0d cyc %0d",
                 bad, wrQ[bad].addr, wrQ[bad].data, wrQ[bad].c, expQ[bad], seqStart + expQ[bad], c0 + bad);
      end
    end
  endtask

  task automatic waitRise();
    for (int g = 0; g < 400 && riseCyc < 0; g++) @(negedge clk);
  endtask

  task automatic doReconfig(input int n, input int b, input bit glitch, input logic [3:0] expMask, input int expWr);
    int k, w, expAck;
    logic [3:0] oldMask;
    reconfig_i = 1'b1;
    activeParts_i = 3'(n);
    busy_i = b > 0;
    @(posedge clk);
    #1;
    k = cyc;
    wrQ.delete();
    ackQ.delete();
    expQ.delete();
    fallCyc = -1;
    riseCyc = -1;
    maskCyc = -1;
    oldMask = curMask;
    curMask = modelMask(n);
    if (initEn)
      for (int p = 0; p < 4; p++)
        if (oldMask[p] && !curMask[p])
          for (int i = 0; i < 16; i++) expQ.push_back(p * 16 + i);
    @(negedge clk);
    reconfig_i = 1'b0;
    for (int i = 0; i < b; i++) begin
      reconfig_i = glitch && i == 1;
      activeParts_i = 3'd1;
      @(negedge clk);
    end
    reconfig_i = 1'b0;
    busy_i = 1'b0;
    if (glitch && expQ.size() > 0) begin
      repeat (5) @(negedge clk);
      reconfig_i = 1'b1;
      @(negedge clk);
      reconfig_i = 1'b0;
    end
    waitRise();
    w = expQ.size();
    expAck = k + b + 3 + (initEn ? (w > 0 ? w : 1) : 0);
    chk("readyFall", fallCyc, k + 1);
    chk("mask", int'(partitionGated_o), int'(expMask));
    if (oldMask != curMask) chk("maskCyc", maskCyc, k + b + 2);
    if (expWr >= 0) chk("tableWr", wrQ.size(), expWr);
    checkWrites(k + b + 3);
    chk("ackCount", ackQ.size(), 1);
    chk("ackCyc", ackQ.size() > 0 ? ackQ[0] : -1, expAck);
    chk("readyRise", riseCyc, expAck + 1);
  endtask

  task automatic doReset();
    int r;
    #2;
    reset = 1'b1;
    reconfig_i = 1'b1;
    activeParts_i = 3'd2;
    busy_i = 1'b0;
    #1;
    chk("rstMask", int'(partitionGated_o), 0);
    chk("rstReady", int'(ramReady_o), 0);
    chk("rstWrEn", int'(initWrEn_o), 0);
    chk("rstAddr", int'(initAddr_o), 0);
    chk("rstData", int'(initData_o), 0);
    chk("rstAck", int'(reconfigAck_o), 0);
    repeat (2) @(negedge clk);
    wrQ.delete();
    ackQ.delete();
    expQ.delete();
    riseCyc = -1;
    curMask = '0;
    if (initEn) for (int i = 0; i < 64; i++) expQ.push_back(i);
    reconfig_i = 1'b0;
    reset = 1'b0;
    r = cyc;
    waitRise();
    checkWrites(r + 1);
    chk("rstAckCount", ackQ.size(), 0);
    chk("rstRise", riseCyc, r + (initEn ? 66 : 2));
    chk("rstMaskAfter", int'(partitionGated_o), 0);
  endtask

  typedef struct {int n; int busy; bit glitch; logic [3:0] mask; int parts;} vecT;
  vecT vec[8];

  initial begin
    vec[0] = '{2, 3, 1'b0, 4'b1100, 0};
    vec[1] = '{4, 0, 1'b0, 4'b0000, 2};
    vec[2] = '{0, 1, 1'b0, 4'b1110, 0};
    vec[3] = '{7, 0, 1'b0, 4'b0000, 3};
    vec[4] = '{4, 2, 1'b0, 4'b0000, 0};
    vec[5] = '{1, 0, 1'b0, 4'b1110, 0};
    vec[6] = '{3, 2, 1'b1, 4'b1000, 2};
    vec[7] = '{5, 1, 1'b0, 4'b0000, 1};
    repeat (2) @(negedge clk);
    doReset();
    for (int i = 0; i < 8; i++)
      doReconfig(vec[i].n, vec[i].busy, vec[i].glitch, vec[i].mask, initEn ? vec[i].parts * 16 : 0);
    for (int i = 0; i < 8; i++) begin
      int n, b;
      n = int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 3));
      doReconfig(n, b, 1'b0, modelMask(n), -1);
    end
    doReconfig(1, 0, 1'b0, 4'b1110, -1);
    reconfig_i = 1'b1;
    activeParts_i = 3'd4;
    busy_i = !initEn;
    @(posedge clk);
    #1;
    wrQ.delete();
    @(negedge clk);
    reconfig_i = 1'b0;
    for (int g = 0; g < 100 && (initEn ? wrQ.size() < 20 : g < 3); g++) begin
      @(negedge clk);
      #1;
    end
    doReset();
    doReconfig(3, 1, 1'b0, 4'b1000, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", nCmp);
    $fatal(1);
  end
endmodule

// File: doc/ram_partition_ctrl.md
# ram_partition_ctrl

Control-side companion to the partitioned shared-decode RAM. It owns the partition gating mask and the RAM reset/initialisation sequence. It accepts a reconfiguration request for the number of active partitions and waits for the client to quiesce. It then applies the new `partitionGated` mask and re-initialises every newly ungated partition through a dedicated write port before asserting `ramReady_o`. It sits between the core's power/config logic and the RAM's `partitionGated_i` and one write port.

## Interface
- `DEPTH`, 64: total RAM entries; must be divisible by `NUM_PARTS`.
- `INDEX`, 6: log2(`DEPTH`).
- `WIDTH`, 32: data width.
- `NUM_PARTS`, 4: number of partitions; must be a power of two.
- `NUM_PARTS_LOG`, 2: log2(`NUM_PARTS`).
- `RESET_SEQ`, 0: init value mode. 0 writes zero; 1 writes `SEQ_START`+address.
- `SEQ_START`, 0: base value for sequential init.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reconfig_i`  in  1  single-cycle request to change the active partition count.
- `activeParts_i`  in  NUM_PARTS_LOG+1  requested active partition count; sampled with `reconfig_i`.
- `busy_i`  in  1  RAM client still has accesses in flight; blocks gating.
- `partitionGated_o`  out  NUM_PARTS  per-partition gate; bit p=1 gates partition p.
- `initWrEn_o`  out  1  init write enable toward the RAM write port.
- `initAddr_o`  out  INDEX  init write address.
- `initData_o`  out  WIDTH  init write data.
- `ramReady_o`  out  1  RAM usable; low during any reconfiguration or init.
- `reconfigAck_o`  out  1  one-cycle pulse when a reconfiguration completes.

## Operation
- FSM states: INIT, IDLE, DRAIN, GATE, DONE. All outputs are registered.
- Reset values:
  - state = INIT, covering all partitions;
  - `partitionGated_o`=0 (all partitions active);
  - `ramReady_o`=0, `initWrEn_o`=0, `initAddr_o`=0, `initData_o`=0, `reconfigAck_o`=0.
- INIT:
  - Visits every pending partition in ascending order and every entry within a partition in ascending order.
  - Issues one write per cycle with `initAddr_o` = p*(DEPTH/NUM_PARTS)+i.
  - `initData_o` = 0, or (SEQ_START+addr) truncated to WIDTH when `RESET_SEQ`=1.
  - After the last write, goes to DONE.
  - If there are no pending partitions, goes straight to DONE.
- IDLE:
  - `ramReady_o`=1.
  - When `reconfig_i`=1, latches the clamped count and goes to DRAIN.
  - Clamp rule: 0 becomes 1; a value greater than `NUM_PARTS` becomes `NUM_PARTS`.
- DRAIN: `ramReady_o`=0. Holds while `busy_i`=1 and leaves on the first cycle `busy_i`=0.
- GATE (one cycle):
  - New mask: bits [n-1:0]=0 and the upper bits=1.
  - Pending set = old mask & ~new mask, i.e. the newly ungated partitions.
  - Then goes to INIT.
- DONE (one cycle):
  - `reconfigAck_o`=1 for this cycle only, except after reset, when it stays 0.
  - `ramReady_o`=1 from the next cycle; then goes to IDLE.
- Boundary and corner cases:
  - `reconfig_i` outside IDLE is ignored and not queued. The requester waits for `reconfigAck_o`.
  - A request equal to the current count still passes DRAIN/GATE/DONE with zero init writes.
  - Shrinking the count causes no init writes.
  - Gated partitions are never written.
  - `reset` asserted mid-sequence aborts immediately and restarts a full INIT over all partitions.
  - `reset` has priority over `reconfig_i`.
  - `initWrEn_o`=0 in every state other than INIT.

## Timing
- Request accepted at edge k: `ramReady_o` is low after edge k+1.
- DRAIN adds one cycle per cycle of `busy_i`=1.
- New `partitionGated_o` is visible one cycle after DRAIN exits.
- Init writes: one per cycle, DEPTH/NUM_PARTS cycles per pending partition, back to back across partitions.
- Post-reset: the first write (addr 0) follows the first edge after `reset` deasserts. `ramReady_o` rises 2 cycles after the last write (address DEPTH-1).
- `reconfigAck_o` and the `ramReady_o` rise are separated by exactly one cycle (ack first).

## Configuration
- `RAM_PART_INIT_EN` defined: INIT behaviour as described above.
- `RAM_PART_INIT_EN` undefined:
  - INIT is removed; `initWrEn_o` is tied to 0.
  - After reset, `ramReady_o` rises on the second edge.
  - Ungated partitions keep undefined contents.
  - All other behaviour is unchanged.

## Test plan
- Reset release, DEPTH=64, NUM_PARTS=4, RESET_SEQ=0 -> 64 consecutive writes, addr 0..63, data 0; then `ramReady_o`=1. No `reconfigAck_o` pulse.
- From 4 active, request 2 with `busy_i` high for 3 cycles -> `ramReady_o` low and DRAIN held 3 cycles; `partitionGated_o`=4'b1100; zero writes; ack pulse; ready again.
- From 2 active, request 4 with RESET_SEQ=1, SEQ_START=100 -> writes addr 32..63 with data 132..163; mask becomes 0; ack pulse.
- `activeParts_i`=0, then 7 -> mask 4'b1110 for the first request, 4'b0000 for the second. Only partitions 1..3 are re-initialised.
- `reconfig_i` pulsed during INIT -> ignored; exactly one ack is produced.
- `reset` asserted at write 20 of a reconfiguration INIT -> outputs return to reset values immediately; a full 64-write init follows.
